// File: rtl/oppm_demodulator.sv
// ----------------------------------------------------------------------------
// oppm_demodulator
//
// Receive side of the OPPM link. Samples the single-wire pulse line, keeps the
// frame position with a slot counter and a symbol counter, and recovers one
// N-bit symbol per frame from the slot that holds the pulse. The external
// sync strobe aligns the counters.
//
// Frame position = symbol_id * L + slot_ct. Frame length F = 2**N * L cycles.
// The result of each frame is registered and strobed with done in the cycle
// after position F-1 is sampled, which is also position 0 of the next frame.
//
// Ports:
//   clk       in   1  clock
//   rst       in   1  synchronous active-high reset (overrides sync)
//   sync      in   1  alignment strobe; the next cycle is frame position 0
//   pulse_in  in   1  received OPPM pulse line
//   data      out  N  recovered symbol, 0 unless valid
//   valid     out  1  frame carried exactly one well-formed pulse
//   err       out  1  frame was malformed
//   done      out  1  one-cycle end-of-frame strobe
//   locked    out  1  aligned and decoding
//
// Build option:
//   OPPM_DEMOD_STRICT_EN  when defined, a pulse whose width differs from
//                         PULSE_CT marks the frame as an error. When not
//                         defined, any run of one or more cycles qualifies
//                         and the width counter is not built.
// ----------------------------------------------------------------------------
module oppm_demodulator #(
    parameter int PULSE_CT = 1,
    parameter int N        = 2,
    parameter int L        = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sync,
    input  logic         pulse_in,
    output logic [N-1:0] data,
    output logic         valid,
    output logic         err,
    output logic         done,
    output logic         locked
);

    localparam int SW = $clog2(L);
    localparam logic [SW-1:0] SLOT_LAST = SW'(L - 1);
    localparam logic [N-1:0]  SYM_LAST  = '1;

`ifdef OPPM_DEMOD_STRICT_EN
    localparam int WW = $clog2(L + 1);
    localparam logic [WW-1:0] WIDTH_MAX = WW'(L);
    localparam logic [WW-1:0] WIDTH_REQ = WW'(PULSE_CT);
`endif

    // Elaboration-time guard on the parameter ranges.
    if (PULSE_CT < 1 || PULSE_CT > L - 1 || L < 2) begin : g_bad_param
        $error("oppm_demodulator: PULSE_CT must be 1..L-1 and L at least 2");
    end

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } top_e;

    typedef enum logic [1:0] {
        TR_EMPTY,
        TR_IN_PULSE,
        TR_GOT,
        TR_BAD
    } trk_e;

    top_e          top_q,   top_d;
    trk_e          trk_q,   trk_d;
    logic [SW-1:0] slot_q,  slot_d;
    logic [N-1:0]  sym_q,   sym_d;
    logic [N-1:0]  cand_q,  cand_d;
    logic          prev_q,  prev_d;
    logic [N-1:0]  data_q,  data_d;
    logic          valid_q, valid_d;
    logic          err_q,   err_d;
    logic          done_q,  done_d;
`ifdef OPPM_DEMOD_STRICT_EN
    logic [WW-1:0] width_q, width_d;
`endif

    logic frame_first;
    logic frame_last;
    logic rising;

    assign frame_first = (slot_q == '0) && (sym_q == '0);
    assign frame_last  = (slot_q == SLOT_LAST) && (sym_q == SYM_LAST);
    assign rising      = pulse_in & ~prev_q;

    always_comb begin
        top_d   = top_q;
        trk_d   = trk_q;
        slot_d  = slot_q;
        sym_d   = sym_q;
        cand_d  = cand_q;
        prev_d  = prev_q;
        data_d  = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        done_d  = 1'b0;
`ifdef OPPM_DEMOD_STRICT_EN
        width_d = width_q;
`endif

        case (top_q)
            ST_UNLOCKED: begin
                slot_d = '0;
                sym_d  = '0;
                trk_d  = TR_EMPTY;
                prev_d = 1'b0;
                if (sync) begin
                    top_d = ST_LOCKED;
                end
            end

            default: begin
                prev_d = pulse_in;

                // Tracker. A high line at position 0 can only be the tail of
                // the previous frame's pulse, so the frame is spoiled at once.
                if (frame_first) begin
                    trk_d = pulse_in ? TR_BAD : TR_EMPTY;
                end else begin
                    case (trk_q)
                        TR_EMPTY: begin
                            if (rising) begin
                                cand_d = sym_q;
                                trk_d  = TR_IN_PULSE;
`ifdef OPPM_DEMOD_STRICT_EN
                                width_d = WW'(1);
`endif
                            end
                        end
                        TR_IN_PULSE: begin
                            if (pulse_in) begin
`ifdef OPPM_DEMOD_STRICT_EN
                                if (width_q != WIDTH_MAX) begin
                                    width_d = width_q + 1'b1;
                                end
`endif
                            end else begin
`ifdef OPPM_DEMOD_STRICT_EN
                                trk_d = (width_q == WIDTH_REQ) ? TR_GOT : TR_BAD;
`else
                                trk_d = TR_GOT;
`endif
                            end
                        end
                        TR_GOT: begin
                            if (rising) begin
                                trk_d = TR_BAD;
                            end
                        end
                        default: begin
                            trk_d = TR_BAD;
                        end
                    endcase
                end

                // Frame verdict uses the tracker state after position F-1 has
                // been taken into account; an open run is closed here.
                if (frame_last) begin
                    done_d = 1'b1;
                    case (trk_d)
                        TR_GOT: begin
                            valid_d = 1'b1;
                            data_d  = cand_d;
                        end
                        TR_IN_PULSE: begin
`ifdef OPPM_DEMOD_STRICT_EN
                            if (width_d == WIDTH_REQ) begin
                                valid_d = 1'b1;
                                data_d  = cand_d;
                            end else begin
                                err_d = 1'b1;
                            end
`else
                            valid_d = 1'b1;
                            data_d  = cand_d;
`endif
                        end
                        TR_BAD: begin
                            err_d = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end

                // Position counters; the symbol counter is exactly N bits so
                // it wraps at 2**N - 1 on its own.
                if (slot_q == SLOT_LAST) begin
                    slot_d = '0;
                    sym_d  = sym_q + 1'b1;
                end else begin
                    slot_d = slot_q + 1'b1;
                end

                // Re-alignment drops the current frame without a result.
                if (sync) begin
                    slot_d  = '0;
                    sym_d   = '0;
                    trk_d   = TR_EMPTY;
                    done_d  = 1'b0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    data_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q   <= ST_UNLOCKED;
            trk_q   <= TR_EMPTY;
            slot_q  <= '0;
            sym_q   <= '0;
            cand_q  <= '0;
            prev_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef OPPM_DEMOD_STRICT_EN
            width_q <= '0;
`endif
        end else begin
            top_q   <= top_d;
            trk_q   <= trk_d;
            slot_q  <= slot_d;
            sym_q   <= sym_d;
            cand_q  <= cand_d;
            prev_q  <= prev_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef OPPM_DEMOD_STRICT_EN
            width_q <= width_d;
`endif
        end
    end

    assign data   = data_q;
    assign valid  = valid_q;
    assign err    = err_q;
    assign done   = done_q;
    assign locked = (top_q == ST_LOCKED);

endmodule
